tone_generator: RTL and testbench
=================================

# tone_generator

Parametrised multi-mode tone source for the sound path. It is the next generation of the fixed square-wave generator. A phase accumulator replaces the compare-and-reset counter, which gives fine frequency control. The block outputs square (programmable duty), sawtooth or triangle samples, or silence. Configuration is double-buffered and applied only at a period boundary, so tone changes are glitch-free. It feeds the downstream mixer/DAC stage one sample per clock.

## Interface
- `OUT_W`, default 8: sample width; also the width of the duty compare.
- `PHASE_W`, default 24: phase accumulator width. Output period is 2^PHASE_W / freq_word clocks.
- `clk` input 1: system clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: run the accumulator. When low, the block idles.
- `freq_word` input PHASE_W: phase increment per clock; captured on `cfg_load`.
- `duty` input OUT_W: square high threshold; captured on `cfg_load`.
- `mode` input 2: 0 square, 1 saw, 2 triangle, 3 silence; captured on `cfg_load`.
- `cfg_load` input 1: one-cycle strobe that captures `freq_word`, `duty` and `mode`.
- `wave_out` output OUT_W: registered sample.
- `wrap` output 1: one-cycle pulse each time the phase wraps.
- `cfg_pending` output 1: high while captured configuration waits for a boundary.

## Operation
- State:
  - `phase` (PHASE_W).
  - Active registers `freq_a`, `duty_a`, `mode_a`.
  - Pending registers `freq_p`, `duty_p`, `mode_p`, plus `cfg_pending`.
- Reset (`reset`=0, asynchronous): every register is 0. `wave_out`=0, `wrap`=0, `cfg_pending`=0. `mode_a`=0 (square), `freq_a`=0, so the block is silent.
- Accumulate (`enable`=1): `phase <= phase + freq_a`, modulo 2^PHASE_W. `wrap <=` carry-out of that add.
- Disabled (`enable`=0): `phase` is cleared to 0, `wrap`=0 and `wave_out` is forced to 0.
- Configuration capture, `cfg_load`=1:
  - Inputs go to the pending registers and `cfg_pending` goes to 1.
  - A repeated load while pending overwrites the pending values; the last load wins.
- Configuration apply: pending goes to active, and `cfg_pending` goes to 0, on the clock edge where either:
  - `enable`=1 and the add carries out (the wrap boundary), or
  - `enable`=0 (immediate apply when idle).
- Load on the apply edge: if `cfg_load` and an apply condition hit the same edge, the new inputs go directly to active and `cfg_pending` stays 0.
- Sample function: `p` = `phase[PHASE_W-1 -: OUT_W]`, using the current register value.
  - Mode 0 (square): all-ones if `p < duty_a`, else 0. `duty`=0 gives a constant 0. `duty`=2^OUT_W-1 gives high for (2^OUT_W-1)/2^OUT_W of the period.
  - Mode 1 (saw): `p`.
  - Mode 2 (triangle): if `p` MSB=0, `{p[OUT_W-2:0],0}`; else the bitwise NOT of that value. The result rises 0 to 2^OUT_W-2, then falls 2^OUT_W-1 to 1.
  - Mode 3 (silence): 0, while `phase` and `wrap` keep running.
- `freq_a`=0: `phase` holds, no `wrap` occurs, and `wave_out` is constant. A pending configuration is then applied only by dropping `enable`.

## Timing
- `wave_out` at edge n+1 = f(`phase`, `mode_a`, `duty_a` as held after edge n). Latency is one clock from the phase register.
- `wrap` is high for exactly the one cycle in which `phase` holds the post-wrap value.
- A new mode or duty first affects `wave_out` one clock after the wrap edge. It never appears mid-period.
- `enable` 1→0: at the next edge, `phase`=0 and `wrap`=0. `wave_out` is 0 from that edge.
- `enable` 0→1: the first add occurs at the next edge. With `phase`=0, `wave_out` after the following edge is f(0 + `freq_a`).
- Reset mid-operation: all outputs go to 0 immediately, with no clock needed. Pending configuration is lost. After release, the block restarts from the reset state.

## Test plan
- Square tone:
  - Stimulus: `OUT_W`=8, `PHASE_W`=24. `cfg_load` with `freq_word`=2^20, `duty`=128, `mode`=0 while `enable`=0, then `enable`=1.
  - Required: `wave_out` alternates 8 cycles 255 / 8 cycles 0; `wrap` pulses every 16 clocks.
- Saw and triangle, same freq:
  - Saw: `wave_out` sequence 0,16,…,240.
  - Triangle: 0,32,…,224, then 255,223,…,31.
  - Both repeat every 16 clocks.
- Deferred update:
  - Stimulus: `cfg_load` with `mode`=1 issued 5 clocks after a `wrap`.
  - Required: `cfg_pending`=1 for the remaining 11 clocks; the square continues until the wrap; the saw starts one clock later; `cfg_pending` returns to 0.
- Load on the wrap edge and a double load:
  - A `cfg_load` coincident with wrap applies immediately and leaves `cfg_pending`=0.
  - Two loads within one period: only the second takes effect at the wrap.
- Zero frequency and duty extremes:
  - `freq_word`=0: `wave_out` is constant and no `wrap` occurs.
  - `duty`=0: output always 0.
  - `duty`=255: output 0 only when `p`=255.
- Reset and disable mid-tone:
  - Assert `reset`=0 asynchronously between edges: `wave_out`, `wrap` and `cfg_pending` go to 0 at once. After release with `enable`=1, the output stays 0 because `freq_a`=0.
  - `enable`=0: `phase` clears on the next edge.

Source files
------------

// File: rtl/tone_generator.sv
// -----------------------------------------------------------------------------
// tone_generator
//
// Phase-accumulator tone source for the sound path. Each clock the phase
// advances by the active frequency word; the top OUT_W bits of the phase are
// shaped into a square (programmable duty), sawtooth or triangle sample, or
// silence. Configuration is double-buffered: a cfg_load strobe captures the
// inputs into pending registers, and they are moved to the active set only at
// a phase wrap (or immediately while disabled), so the waveform never changes
// shape mid-period.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       run the accumulator; low clears phase and mutes the output
//   freq_word    phase increment per clock (captured on cfg_load)
//   duty         square-wave high threshold (captured on cfg_load)
//   mode         0 square, 1 saw, 2 triangle, 3 silence (captured on cfg_load)
//   cfg_load     one-cycle strobe capturing freq_word / duty / mode
//   wave_out     registered sample, one clock behind the phase register
//   wrap         one-cycle pulse while phase holds its post-wrap value
//   cfg_pending  captured configuration is waiting for a boundary
// -----------------------------------------------------------------------------
module tone_generator #(
    parameter int OUT_W   = 8,
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [OUT_W-1:0]   duty,
    input  logic [1:0]         mode,
    input  logic               cfg_load,
    output logic [OUT_W-1:0]   wave_out,
    output logic               wrap,
    output logic               cfg_pending
);

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SILENT = 2'd3
    } mode_t;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] freq_a;
    logic [PHASE_W-1:0] freq_p;
    logic [OUT_W-1:0]   duty_a;
    logic [OUT_W-1:0]   duty_p;
    mode_t              mode_a;
    mode_t              mode_p;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               apply;
    logic [PHASE_W-1:0] phase_next;
    logic [OUT_W-1:0]   p;
    logic [OUT_W-1:0]   ramp;
    logic [OUT_W-1:0]   tri_val;
    logic [OUT_W-1:0]   sample;

    // -------------------------------------------------------------------------
    // Accumulator and boundary detection
    // -------------------------------------------------------------------------
    always_comb begin
        sum   = {1'b0, phase} + {1'b0, freq_a};
        carry = sum[PHASE_W];
        // Idle applies immediately; running applies only on the wrap edge.
        apply = ~enable | carry;
        if (enable) begin
            phase_next = sum[PHASE_W-1:0];
        end else begin
            phase_next = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Sample shaping from the current phase and active configuration
    // -------------------------------------------------------------------------
    assign p = phase[PHASE_W-1 -: OUT_W];

    // Triangle: double the lower bits on the rising half, invert them on the
    // falling half, giving 0..2^OUT_W-2 up then 2^OUT_W-1..1 down.
    always_comb begin
        ramp = {p[OUT_W-2:0], 1'b0};
        if (p[OUT_W-1]) begin
            tri_val = ~ramp;
        end else begin
            tri_val = ramp;
        end
    end

    always_comb begin
        sample = '0;
        case (mode_a)
            MODE_SQUARE: sample = (p < duty_a) ? '1 : '0;
            MODE_SAW:    sample = p;
            MODE_TRI:    sample = tri_val;
            MODE_SILENT: sample = '0;
            default:     sample = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Phase, wrap and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= '0;
            wrap     <= 1'b0;
            wave_out <= '0;
        end else begin
            phase <= phase_next;
            if (enable) begin
                wrap     <= carry;
                wave_out <= sample;
            end else begin
                wrap     <= 1'b0;
                wave_out <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Double-buffered configuration
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            freq_a      <= '0;
            duty_a      <= '0;
            mode_a      <= MODE_SQUARE;
            freq_p      <= '0;
            duty_p      <= '0;
            mode_p      <= MODE_SQUARE;
            cfg_pending <= 1'b0;
        end else if (apply) begin
            cfg_pending <= 1'b0;
            // A load landing on the boundary bypasses the pending stage.
            if (cfg_load) begin
                freq_a <= freq_word;
                duty_a <= duty;
                mode_a <= mode_t'(mode);
            end else if (cfg_pending) begin
                freq_a <= freq_p;
                duty_a <= duty_p;
                mode_a <= mode_p;
            end
        end else if (cfg_load) begin
            // Repeated loads before the boundary simply overwrite.
            freq_p      <= freq_word;
            duty_p      <= duty;
            mode_p      <= mode_t'(mode);
            cfg_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

    localparam int OUT_W   = 8;
    localparam int PHASE_W = 24;
    localparam longint PERIOD = 64'd16777216;  // 2^PHASE_W

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [PHASE_W-1:0] freq_word;
    logic [OUT_W-1:0]   duty;
    logic [1:0]         mode;
    logic               cfg_load;
    logic [OUT_W-1:0]   wave_out;
    logic               wrap;
    logic               cfg_pending;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    tone_generator #(.OUT_W(OUT_W), .PHASE_W(PHASE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .freq_word   (freq_word),
        .duty        (duty),
        .mode        (mode),
        .cfg_load    (cfg_load),
        .wave_out    (wave_out),
        .wrap        (wrap),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Waveform as a function of the phase value, written from the sample rules
    function automatic int wave_fn(input longint ph, input int md, input int dt);
        int p;
        p = int'(ph / 65536);
        case (md)
            0:       return (p < dt) ? 255 : 0;
            1:       return p;
            2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            default: return 0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    longint m_phase = 0;
    longint m_sum   = 0;
    int     m_fa = 0, m_da = 0, m_ma = 0;
    int     m_fp = 0, m_dp = 0, m_mp = 0;
    bit     m_pend = 0, m_wrap = 0, m_bnd = 0;
    int     m_wave = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = 0; m_fa = 0; m_da = 0; m_ma = 0;
                m_fp = 0; m_dp = 0; m_mp = 0;
                m_pend = 0; m_wrap = 0; m_wave = 0;
            end else begin
                if (enable) begin
                    m_wave  = wave_fn(m_phase, m_ma, m_da);
                    m_sum   = m_phase + longint'(m_fa);
                    m_bnd   = (m_sum >= PERIOD);
                    m_wrap  = m_bnd;
                    m_phase = m_sum % PERIOD;
                end else begin
                    m_wave  = 0;
                    m_wrap  = 0;
                    m_phase = 0;
                    m_bnd   = 1;
                end
                if (m_bnd) begin
                    if (cfg_load) begin
                        m_fa = int'(freq_word); m_da = int'(duty); m_ma = int'(mode);
                    end else if (m_pend) begin
                        m_fa = m_fp; m_da = m_dp; m_ma = m_mp;
                    end
                    m_pend = 0;
                end else if (cfg_load) begin
                    m_fp = int'(freq_word); m_dp = int'(duty); m_mp = int'(mode);
                    m_pend = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mdl_wave", wave_out, m_wave);
                check("mdl_wrap", wrap, m_wrap);
                check("mdl_pend", cfg_pending, m_pend);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic restart(input int fw, input int dt, input int md);
        enable    = 1'b0;
        cfg_load  = 1'b1;
        freq_word = fw[PHASE_W-1:0];
        duty      = dt[OUT_W-1:0];
        mode      = md[1:0];
        @(negedge clk);
        cfg_load  = 1'b0;
        enable    = 1'b1;
    endtask

    task automatic load(input int fw, input int dt, input int md);
        cfg_load  = 1'b1;
        freq_word = fw[PHASE_W-1:0];
        duty      = dt[OUT_W-1:0];
        mode      = md[1:0];
    endtask

    initial begin
        int pend_cnt;
        int j;
        reset = 1'b0; enable = 1'b0; cfg_load = 1'b0;
        freq_word = '0; duty = '0; mode = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wave", wave_out, 0);
        check("rst_wrap", wrap, 0);
        check("rst_pend", cfg_pending, 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Square, duty 128: 8 high / 8 low, wrap every 16
        restart(1 << 20, 128, 0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check("sq_wave", wave_out, (((k - 1) % 16) < 8) ? 255 : 0);
            check("sq_wrap", wrap, (k % 16 == 0) ? 1 : 0);
        end

        // Saw
        restart(1 << 20, 0, 1);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check("saw_wave", wave_out, 16 * ((k - 1) % 16));
        end

        // Triangle
        restart(1 << 20, 0, 2);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            j = (k - 1) % 16;
            check("tri_wave", wave_out, (j < 8) ? 32 * j : 255 - 32 * (j - 8));
        end

        // Deferred update: saw loaded 5 clocks after the wrap at edge 16
        restart(1 << 20, 128, 0);
        pend_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            pend_cnt += int'(cfg_pending);
            if (k == 24) check("def_still_square", wave_out, 255);
            if (k == 32) check("def_wrap", wrap, 1);
            if (k == 32) check("def_pend_clear", cfg_pending, 0);
            if (k == 34) check("def_saw_start", wave_out, 16);
            if (k == 40) check("def_saw_run", wave_out, 112);
            if (k == 20) load(1 << 20, 128, 1);
            if (k == 21) cfg_load = 1'b0;
        end
        check("def_pend_cycles", pend_cnt, 11);

        // Load on the wrap edge, then two loads in one period
        restart(1 << 20, 128, 0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 16) check("lw_wrap", wrap, 1);
            if (k == 16) check("lw_pend", cfg_pending, 0);
            if (k == 18) check("lw_saw", wave_out, 16);
            if (k == 30) check("dbl_pend", cfg_pending, 1);
            if (k == 32) check("dbl_pend_clear", cfg_pending, 0);
            if (k == 34) check("dbl_second_hi", wave_out, 255);
            if (k == 37) check("dbl_second_lo", wave_out, 0);
            if (k == 15) load(1 << 20, 128, 1);
            if (k == 16) cfg_load = 1'b0;
            if (k == 20) load(1 << 20, 128, 2);
            if (k == 21) cfg_load = 1'b0;
            if (k == 25) load(1 << 20, 64, 0);
            if (k == 26) cfg_load = 1'b0;
        end

        // Zero frequency applied at a wrap leaving phase at 0x080000
        restart(24'h180000, 0, 1);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 11) check("zf_wrap", wrap, 1);
            if (k >= 12) check("zf_const", wave_out, 8);
            if (k >= 12) check("zf_nowrap", wrap, 0);
            if (k == 32) check("zf_pend_held", cfg_pending, 1);
            if (k == 10) load(0, 0, 1);
            if (k == 11) cfg_load = 1'b0;
            if (k == 15) load(1 << 20, 0, 3);
            if (k == 16) cfg_load = 1'b0;
        end
        enable = 1'b0;
        @(negedge clk);
        check("zf_idle_apply", cfg_pending, 0);

        // Duty extremes
        restart(1 << 20, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("duty0", wave_out, 0);
        end
        restart(1 << 16, 255, 0);
        for (int k = 1; k <= 258; k++) begin
            @(negedge clk);
            check("duty255", wave_out, (k == 256) ? 0 : 255);
        end

        // Disable mid-tone, then re-enable
        restart(1 << 20, 0, 1);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("dis_pre", wave_out, 64);
        enable = 1'b0;
        @(negedge clk);
        check("dis_wave", wave_out, 0);
        check("dis_wrap", wrap, 0);
        enable = 1'b1;
        @(negedge clk);
        check("en_first", wave_out, 0);
        @(negedge clk);
        check("en_second", wave_out, 16);

        // Asynchronous reset mid-tone with a pending configuration
        restart(1 << 20, 128, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) load(1 << 20, 0, 1);
            if (k == 4) cfg_load = 1'b0;
        end
        check("ar_pre_wave", wave_out, 255);
        check("ar_pre_pend", cfg_pending, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_wave", wave_out, 0);
        check("ar_wrap", wrap, 0);
        check("ar_pend", cfg_pending, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("ar_post_wave", wave_out, 0);
            check("ar_post_wrap", wrap, 0);
            check("ar_post_pend", cfg_pending, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
